// File: rtl/decode_control_stage_pkg.sv
// Shared definitions for the decode stage: instruction field positions,
// opcode and ALU encodings, and the decode control word.
package decode_control_stage_pkg;

   localparam int unsigned DATA_W     = 36;
   localparam int unsigned INSTR_W    = 24;
   localparam int unsigned OPCODE_MSB = 23;
   localparam int unsigned OPCODE_LSB = 20;
   localparam int unsigned RD_MSB     = 19;
   localparam int unsigned RD_LSB     = 16;
   localparam int unsigned RS1_MSB    = 15;
   localparam int unsigned RS1_LSB    = 12;
   localparam int unsigned RS2_MSB    = 11;
   localparam int unsigned RS2_LSB    = 8;
   localparam int unsigned IMM_MSB    = 11;
   localparam int unsigned IMM_W      = 12;

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0,
      OP_ADD   = 4'h1,
      OP_SUB   = 4'h2,
      OP_MUL   = 4'h3,
      OP_AND   = 4'h4,
      OP_OR    = 4'h5,
      OP_XOR   = 4'h6,
      OP_SHL   = 4'h7,
      OP_SHR   = 4'h8,
      OP_ADDI  = 4'h9,
      OP_LOAD  = 4'hA,
      OP_STORE = 4'hB,
      OP_B     = 4'hC,
      OP_BEQ   = 4'hD,
      OP_BLT   = 4'hE,
      OP_OUT   = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SHL = 3'b101,
      ALU_SHR = 3'b110,
      ALU_MUL = 3'b111
   } alu_e;

   typedef struct packed {
      logic regWrite;
      logic memWrite;
      logic resultSel;
      logic data2Sel;
      logic outFlag;
      alu_e alu;
   } ctrl_t;

endpackage

// File: rtl/decode_control_stage_regfile.sv
// 16-entry register file: two read ports with write-through bypass,
// register 15 aliases PC+1 and is never written.
module decode_control_stage_regfile #(
   parameter int unsigned WIDTH        = 36,
   parameter int unsigned REGNUM       = 16,
   parameter int unsigned ADDRESSWIDTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDRESSWIDTH-1:0] readAddr1,
   input  logic [ADDRESSWIDTH-1:0] readAddr2,
   input  logic                    writeEnable,
   input  logic [ADDRESSWIDTH-1:0] writeAddr,
   input  logic [WIDTH-1:0]        writeData,
   input  logic [WIDTH-1:0]        pcPlus1,
   output logic [WIDTH-1:0]        readData1,
   output logic [WIDTH-1:0]        readData2
);

   localparam logic [ADDRESSWIDTH-1:0] PC_REG = ADDRESSWIDTH'(REGNUM - 1);

   logic [WIDTH-1:0] regs_q [0:REGNUM-2];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < REGNUM - 1; i++) begin
            regs_q[i] <= '0;
         end
      end else if (writeEnable && (writeAddr != PC_REG)) begin
         regs_q[writeAddr] <= writeData;
      end
   end

   // PC alias takes priority over bypass, so a write aimed at r15 never leaks into a read.
   always_comb begin
      readData1 = '0;
      if (readAddr1 == PC_REG) begin
         readData1 = pcPlus1;
      end else if (writeEnable && (writeAddr == readAddr1)) begin
         readData1 = writeData;
      end else begin
         readData1 = regs_q[readAddr1];
      end
   end

   always_comb begin
      readData2 = '0;
      if (readAddr2 == PC_REG) begin
         readData2 = pcPlus1;
      end else if (writeEnable && (writeAddr == readAddr2)) begin
         readData2 = writeData;
      end else begin
         readData2 = regs_q[readAddr2];
      end
   end

endmodule

// File: rtl/decode_control_stage_wbmux.sv
// Write-back result selection: ALU result or memory data.
module decode_control_stage_wbmux #(
   parameter int unsigned WIDTH = 36
) (
   input  logic             select,
   input  logic [WIDTH-1:0] aluOutput,
   input  logic [WIDTH-1:0] memData,
   output logic [WIDTH-1:0] result
);

   assign result = select ? memData : aluOutput;

endmodule

// File: rtl/decode_control_stage.sv
// Decode stage: instruction cracking, operand read, control word generation,
// execute-stage branch decision and write-back selection.
module decode_control_stage
   import decode_control_stage_pkg::*;
#(
   parameter int unsigned WIDTH            = 36,
   parameter int unsigned REGNUM           = 16,
   parameter int unsigned ADDRESSWIDTH     = 4,
   parameter int unsigned OPCODEWIDTH      = 4,
   parameter int unsigned INSTRUCTIONWIDTH = 24
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [INSTRUCTIONWIDTH-1:0] instructionD,
   input  logic [WIDTH-1:0]            pcPlus1,
   input  logic [OPCODEWIDTH-1:0]      opcodeE,
   input  logic [3:0]                  flagsE,
   input  logic                        writeEnableWB,
   input  logic [ADDRESSWIDTH-1:0]     writeAddressWB,
   input  logic                        resultSelectWB,
   input  logic [WIDTH-1:0]            aluOutputWB,
   input  logic [WIDTH-1:0]            memDataWB,
   output logic [WIDTH-1:0]            resultWB,
   output logic [WIDTH-1:0]            reg1Content,
   output logic [WIDTH-1:0]            reg2Content,
   output logic [WIDTH-1:0]            immediate,
   output logic [ADDRESSWIDTH-1:0]     rdAddr,
   output logic [ADDRESSWIDTH-1:0]     rs1Addr,
   output logic [ADDRESSWIDTH-1:0]     rs2Addr,
   output logic [OPCODEWIDTH-1:0]      opcodeD,
   output logic                        regWriteD,
   output logic                        memWriteD,
   output logic                        resultSelectD,
   output logic                        data2SelectD,
   output logic                        outFlagD,
   output logic [2:0]                  aluControlD,
   output logic                        takeBranchE
);

   opcode_e op;
   ctrl_t   ctrl;
   logic    flagN, flagZ, flagV;
   logic    carry_unused;

   assign op      = opcode_e'(instructionD[OPCODE_MSB:OPCODE_LSB]);
   assign opcodeD = instructionD[OPCODE_MSB:OPCODE_LSB];
   assign rdAddr  = instructionD[RD_MSB:RD_LSB];
   assign rs1Addr = instructionD[RS1_MSB:RS1_LSB];
   // STORE reads its data register through the rd field on the second port.
   assign rs2Addr = (op == OP_STORE) ? instructionD[RD_MSB:RD_LSB]
                                     : instructionD[RS2_MSB:RS2_LSB];
   assign immediate = {{(WIDTH-IMM_W){instructionD[IMM_MSB]}}, instructionD[IMM_MSB:0]};

   always_comb begin
      ctrl = '{regWrite: 1'b0, memWrite: 1'b0, resultSel: 1'b0,
               data2Sel: 1'b0, outFlag: 1'b0, alu: ALU_ADD};
      case (op)
         OP_ADD:   begin ctrl.regWrite = 1'b1; ctrl.alu = ALU_ADD; end
         OP_SUB:   begin ctrl.regWrite = 1'b1; ctrl.alu = ALU_SUB; end
         OP_MUL:   begin ctrl.regWrite = 1'b1; ctrl.alu = ALU_MUL; end
         OP_AND:   begin ctrl.regWrite = 1'b1; ctrl.alu = ALU_AND; end
         OP_OR:    begin ctrl.regWrite = 1'b1; ctrl.alu = ALU_OR;  end
         OP_XOR:   begin ctrl.regWrite = 1'b1; ctrl.alu = ALU_XOR; end
         OP_SHL:   begin ctrl.regWrite = 1'b1; ctrl.alu = ALU_SHL; end
         OP_SHR:   begin ctrl.regWrite = 1'b1; ctrl.alu = ALU_SHR; end
         OP_ADDI:  begin ctrl.regWrite = 1'b1; ctrl.data2Sel = 1'b1; end
         OP_LOAD:  begin ctrl.regWrite = 1'b1; ctrl.resultSel = 1'b1; ctrl.data2Sel = 1'b1; end
         OP_STORE: begin ctrl.memWrite = 1'b1; ctrl.data2Sel = 1'b1; end
         OP_B, OP_BEQ, OP_BLT: ctrl.data2Sel = 1'b1;
         OP_OUT:   begin ctrl.data2Sel = 1'b1; ctrl.outFlag = 1'b1; end
         default:  ;
      endcase
   end

   assign regWriteD     = ctrl.regWrite;
   assign memWriteD     = ctrl.memWrite;
   assign resultSelectD = ctrl.resultSel;
   assign data2SelectD  = ctrl.data2Sel;
   assign outFlagD      = ctrl.outFlag;
   assign aluControlD   = ctrl.alu;

   assign flagN        = flagsE[3];
   assign flagZ        = flagsE[2];
   assign flagV        = flagsE[1];
   assign carry_unused = flagsE[0];

   always_comb begin
      takeBranchE = 1'b0;
      case (opcode_e'(opcodeE))
         OP_B:    takeBranchE = 1'b1;
         OP_BEQ:  takeBranchE = flagZ;
         OP_BLT:  takeBranchE = flagN ^ flagV;
         default: takeBranchE = 1'b0;
      endcase
   end

   decode_control_stage_wbmux #(
      .WIDTH(WIDTH)
   ) u_wbmux (
      .select   (resultSelectWB),
      .aluOutput(aluOutputWB),
      .memData  (memDataWB),
      .result   (resultWB)
   );

   decode_control_stage_regfile #(
      .WIDTH       (WIDTH),
      .REGNUM      (REGNUM),
      .ADDRESSWIDTH(ADDRESSWIDTH)
   ) u_regfile (
      .clock      (clock),
      .reset      (reset),
      .readAddr1  (rs1Addr),
      .readAddr2  (rs2Addr),
      .writeEnable(writeEnableWB),
      .writeAddr  (writeAddressWB),
      .writeData  (resultWB),
      .pcPlus1    (pcPlus1),
      .readData1  (reg1Content),
      .readData2  (reg2Content)
   );

endmodule

// File: tb/tb_decode_control_stage.sv
// Directed and randomized checks of decode_control_stage against a
// behavioural model of the register file, decoder and branch rules.
module tb_decode_control_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [23:0] instructionD;
   logic [35:0] pcPlus1;
   logic [3:0]  opcodeE;
   logic [3:0]  flagsE;
   logic        writeEnableWB;
   logic [3:0]  writeAddressWB;
   logic        resultSelectWB;
   logic [35:0] aluOutputWB;
   logic [35:0] memDataWB;
   logic [35:0] resultWB, reg1Content, reg2Content, immediate;
   logic [3:0]  rdAddr, rs1Addr, rs2Addr, opcodeD;
   logic        regWriteD, memWriteD, resultSelectD, data2SelectD, outFlagD;
   logic [2:0]  aluControlD;
   logic        takeBranchE;

   int unsigned tests = 0;
   int unsigned failures = 0;

   logic [35:0] mdl [15];
   logic [2:0]  alu_of [16] = '{3'd0, 3'd0, 3'd1, 3'd7, 3'd2, 3'd3, 3'd4, 3'd5,
                                 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

   always #5 clock = ~clock;

   decode_control_stage #(
      .WIDTH(36), .REGNUM(16), .ADDRESSWIDTH(4), .OPCODEWIDTH(4), .INSTRUCTIONWIDTH(24)
   ) dut (
      .clock(clock), .reset(reset), .instructionD(instructionD), .pcPlus1(pcPlus1),
      .opcodeE(opcodeE), .flagsE(flagsE), .writeEnableWB(writeEnableWB),
      .writeAddressWB(writeAddressWB), .resultSelectWB(resultSelectWB),
      .aluOutputWB(aluOutputWB), .memDataWB(memDataWB), .resultWB(resultWB),
      .reg1Content(reg1Content), .reg2Content(reg2Content), .immediate(immediate),
      .rdAddr(rdAddr), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .opcodeD(opcodeD),
      .regWriteD(regWriteD), .memWriteD(memWriteD), .resultSelectD(resultSelectD),
      .data2SelectD(data2SelectD), .outFlagD(outFlagD), .aluControlD(aluControlD),
      .takeBranchE(takeBranchE)
   );

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] wb_value();
      return resultSelectWB ? memDataWB : aluOutputWB;
   endfunction

   function automatic logic [35:0] model_read(input logic [3:0] a);
      if (a == 4'd15) return pcPlus1;
      if (writeEnableWB && writeAddressWB == a) return wb_value();
      return mdl[a];
   endfunction

   function automatic logic model_branch();
      case (opcodeE)
         4'hC:    return 1'b1;
         4'hD:    return flagsE[2];
         4'hE:    return flagsE[3] ^ flagsE[1];
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_all(input string tag);
      int unsigned op;
      logic [3:0]  rd, rs1, rs2;
      logic [11:0] imm12;
      op    = int'(instructionD[23:20]);
      rd    = instructionD[19:16];
      rs1   = instructionD[15:12];
      rs2   = (op == 11) ? rd : instructionD[11:8];
      imm12 = instructionD[11:0];
      check({tag, ".result"}, resultWB, wb_value());
      check({tag, ".reg1"}, reg1Content, model_read(rs1));
      check({tag, ".reg2"}, reg2Content, model_read(rs2));
      check({tag, ".imm"}, immediate, 36'($signed(imm12)));
      check({tag, ".rd"}, 36'(rdAddr), 36'(rd));
      check({tag, ".rs1"}, 36'(rs1Addr), 36'(rs1));
      check({tag, ".rs2"}, 36'(rs2Addr), 36'(rs2));
      check({tag, ".op"}, 36'(opcodeD), 36'(op));
      check({tag, ".regWrite"}, 36'(regWriteD), 36'(op >= 1 && op <= 10));
      check({tag, ".memWrite"}, 36'(memWriteD), 36'(op == 11));
      check({tag, ".resSel"}, 36'(resultSelectD), 36'(op == 10));
      check({tag, ".data2Sel"}, 36'(data2SelectD), 36'(op >= 9));
      check({tag, ".outFlag"}, 36'(outFlagD), 36'(op == 15));
      check({tag, ".alu"}, 36'(aluControlD), 36'(alu_of[op]));
      check({tag, ".branch"}, 36'(takeBranchE), 36'(model_branch()));
   endtask

   // Advance one cycle, committing the write-back into the model at the edge.
   task automatic tick();
      @(posedge clock);
      if (reset && writeEnableWB && writeAddressWB != 4'd15)
         mdl[writeAddressWB] = wb_value();
      @(negedge clock);
   endtask

   initial begin
      for (int i = 0; i < 15; i++) mdl[i] = '0;
      reset = 1'b0;
      instructionD = 24'h103F00;
      pcPlus1 = 36'h10;
      opcodeE = 4'h0; flagsE = 4'h0;
      writeEnableWB = 1'b0; writeAddressWB = 4'h0; resultSelectWB = 1'b0;
      aluOutputWB = '0; memDataWB = '0;

      #2;
      check("rst_reg1", reg1Content, 36'h0);
      check("rst_reg2_pc", reg2Content, 36'h10);
      check_all("rst");

      @(negedge clock);
      reset = 1'b1;

      writeEnableWB = 1'b1; writeAddressWB = 4'd3; resultSelectWB = 1'b0; aluOutputWB = 36'h123;
      tick();
      writeEnableWB = 1'b0;
      instructionD = 24'h113300;
      #1;
      check("add_reg1", reg1Content, 36'h123);
      check("add_reg2", reg2Content, 36'h123);
      check("add_regWrite", 36'(regWriteD), 36'h1);
      check("add_alu", 36'(aluControlD), 36'h0);
      check_all("add");

      writeEnableWB = 1'b1; writeAddressWB = 4'd4; resultSelectWB = 1'b1;
      memDataWB = 36'hABC; aluOutputWB = 36'h555;
      instructionD = 24'h104000;
      #1;
      check("bypass_reg1", reg1Content, 36'hABC);
      check("bypass_result", resultWB, 36'hABC);
      check_all("bypass");
      tick();
      writeEnableWB = 1'b0;

      writeEnableWB = 1'b1; writeAddressWB = 4'd15; aluOutputWB = 36'h999; resultSelectWB = 1'b0;
      pcPlus1 = 36'h42;
      instructionD = 24'h1FF000;
      #1;
      check("r15_bypass_blocked", reg1Content, 36'h42);
      tick();
      writeEnableWB = 1'b0;
      #1;
      check("r15_after_write", reg1Content, 36'h42);

      instructionD = 24'h912FFF;
      #1;
      check("addi_imm", immediate, 36'hF_FFFF_FFFF);
      check("addi_d2", 36'(data2SelectD), 36'h1);
      check_all("addi");

      instructionD = 24'hB52007;
      #1;
      check("store_rs2", 36'(rs2Addr), 36'h5);
      check("store_rs1", 36'(rs1Addr), 36'h2);
      check("store_memWrite", 36'(memWriteD), 36'h1);
      check("store_regWrite", 36'(regWriteD), 36'h0);
      check_all("store");

      opcodeE = 4'hD; flagsE = 4'b0100; #1; check("beq_z1", 36'(takeBranchE), 36'h1);
      flagsE = 4'b0000; #1;                  check("beq_z0", 36'(takeBranchE), 36'h0);
      opcodeE = 4'hE; flagsE = 4'b1000; #1; check("blt_n1v0", 36'(takeBranchE), 36'h1);
      flagsE = 4'b1010; #1;                  check("blt_n1v1", 36'(takeBranchE), 36'h0);
      opcodeE = 4'hC; flagsE = 4'b0000; #1; check("b_always", 36'(takeBranchE), 36'h1);
      opcodeE = 4'h1; flagsE = 4'b1111; #1; check("nonbranch", 36'(takeBranchE), 36'h0);

      for (int n = 0; n < 300; n++) begin
         instructionD   = 24'($urandom);
         pcPlus1        = {4'($urandom), 32'($urandom)};
         opcodeE        = 4'($urandom);
         flagsE         = 4'($urandom);
         writeEnableWB  = ($urandom_range(0, 3) != 0);
         writeAddressWB = 4'($urandom);
         resultSelectWB = 1'($urandom);
         aluOutputWB    = {4'($urandom), 32'($urandom)};
         memDataWB      = {4'($urandom), 32'($urandom)};
         #1;
         check_all("rand");
         tick();
      end

      // Reset asserted while a write is pending: clears immediately and beats the edge.
      writeEnableWB = 1'b1; writeAddressWB = 4'd7; resultSelectWB = 1'b0; aluOutputWB = 36'h777;
      mdl[7] = 36'h0;
      writeEnableWB = 1'b0;
      instructionD = 24'h107300;
      #1;
      writeEnableWB = 1'b1;
      #2;
      reset = 1'b0;
      for (int i = 0; i < 15; i++) mdl[i] = '0;
      writeEnableWB = 1'b0;
      instructionD = 24'h10A300;
      #1;
      check("async_rst_reg1", reg1Content, 36'h0);
      check("async_rst_reg2", reg2Content, 36'h0);
      writeEnableWB = 1'b1;
      tick();
      writeEnableWB = 1'b0;
      instructionD = 24'h107700;
      #1;
      check("rst_midwrite_r7", reg1Content, 36'h0);
      check_all("rst_hold");
      reset = 1'b1;
      tick();
      #1;
      check("post_rst_r7", reg1Content, 36'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/decode_control_stage.md
# decode_control_stage

Decode-stage slice of the 5-stage, 36-bit pipelined processor. It cracks the 24-bit instruction held in the fetch/decode register, reads two operands from a 16-entry register file, and generates the main control word. It also evaluates the branch decision for the instruction in execute and performs the write-back result selection plus register-file write. It sits between the fetch/decode pipeline register and the decode/execute pipeline register.

## Interface
- WIDTH, 36, datapath width
- REGNUM, 16, register count
- ADDRESSWIDTH, 4, register address width
- OPCODEWIDTH, 4, opcode width
- INSTRUCTIONWIDTH, 24, instruction width

Reset is asynchronous, active-low (`reset`). Single clock (`clock`).

- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- instructionD  in  24  instruction in decode
- pcPlus1  in  WIDTH  PC+1 from fetch
- opcodeE  in  4  opcode of instruction in execute
- flagsE  in  4  {N,Z,V,C} latched with execute instruction
- writeEnableWB  in  1  register write enable from WB stage
- writeAddressWB  in  4  destination register from WB
- resultSelectWB  in  1  0 = ALU result, 1 = memory data
- aluOutputWB, memDataWB  in  WIDTH  write-back candidates
- resultWB  out  WIDTH  selected write-back value (forwarding/regfile data)
- reg1Content, reg2Content  out  WIDTH  operand values
- immediate  out  WIDTH  sign-extended instr[11:0]
- rdAddr, rs1Addr, rs2Addr  out  4  register addresses
- opcodeD  out  4  instr[23:20]
- regWriteD, memWriteD, resultSelectD, data2SelectD, outFlagD  out  1  control word
- aluControlD  out  3  ALU operation
- takeBranchE  out  1  redirect fetch to ALU result

## Operation
- Fields: opcode [23:20], rd [19:16], rs1 [15:12], rs2 [11:8], imm [11:0] sign-extended to 36 bits.
- rs2Addr = rd field for STORE (opcode B), else instr[11:8].
- ALU codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 mul.
- Opcodes (regWrite/memWrite/resultSel/data2Sel/outFlag, alu):
  - 0 NOP 0/0/0/0/0, 000
  - 1 ADD 1/0/0/0/0, 000
  - 2 SUB 1/0/0/0/0, 001
  - 3 MUL 1/0/0/0/0, 111
  - 4 AND 1/0/0/0/0, 010
  - 5 OR 1/0/0/0/0, 011
  - 6 XOR 1/0/0/0/0, 100
  - 7 SHL 1/0/0/0/0, 101
  - 8 SHR 1/0/0/0/0, 110
  - 9 ADDI 1/0/0/1/0, 000
  - A LOAD 1/0/1/1/0, 000
  - B STORE 0/1/0/1/0, 000
  - C B, D BEQ, E BLT all 0/0/0/1/0, 000 (target = rs1 + imm; rs1 = 15 gives PC-relative)
  - F OUT 0/0/0/1/1, 000
- takeBranchE: opcodeE C → 1; D → Z; E → N xor V; all others 0.
- resultWB = resultSelectWB ? memDataWB : aluOutputWB (pure combinational).
- Register file: 16 × 36.
  - Reads of address 15 return pcPlus1; writes to 15 are ignored.
  - All other registers, including 0, are ordinary.
- Write-through: if writeEnableWB and writeAddressWB equals a read address (≠15), the read returns resultWB in the same cycle.

## Timing
- Decode, control, branch, mux and reads: combinational, zero latency.
- Register write: rising clock edge when writeEnableWB = 1.
- Reset low asynchronously clears registers 0–14 to 0. Outputs are combinational, so after reset reads return 0, except register 15, which returns pcPlus1.
- Reset mid-write: reset wins and the register is 0.

## Structure
- Shared package: opcode constants, ALU-code constants, control-word struct, field positions.
- Sub-modules: register_file (16×36, bypass, r15 = PC+1) and the 2:1 write-back mux. Controller decode is an always_comb case in the top.

## Test plan
- Reset low; read rs1 = 3, rs2 = 15 with pcPlus1 = 0x10 → reg1 = 0, reg2 = 0x10.
- Write r3 = 0x123 (writeEnableWB = 1, resultSelectWB = 0, aluOutputWB = 0x123), clock, then ADD r1,r3,r3 → reg1Content = 0x123; controls 1/0/0/0/0, alu 000.
- Same-cycle bypass: write r4 from memDataWB = 0xABC (resultSelectWB = 1) while decoding rs1 = 4 → reg1Content = 0xABC, resultWB = 0xABC.
- ADDI with imm 0xFFF → immediate = all ones (36 bits), data2SelectD = 1.
- STORE 0xB5_2_0_07 → rs2Addr = 5, rs1Addr = 2, memWriteD = 1, regWriteD = 0.
- Branches:
  - opcodeE = D with Z = 1 → takeBranchE = 1; Z = 0 → 0.
  - opcodeE = E with N = 1, V = 0 → 1; N = 1, V = 1 → 0.
  - opcodeE = 1 → 0.
